// File: rtl/nibble_serial_adder.sv
// Serial W=4*NIBBLES adder: one 4-bit slice per clock, with the carry held in a register between slices.
// Latency is NIBBLES cycles from input handshake to out_valid. out_ready low holds DONE with outputs frozen.
// Optional signed-overflow output out_ovf is present when OVERFLOW_FLAG_EN is defined.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
`ifdef OVERFLOW_FLAG_EN
  output logic                   out_ovf,
`endif
  output logic                   out_co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            co_q, co_d;
  logic [4:0]      nib_sum;
`ifdef OVERFLOW_FLAG_EN
  logic            ovf_q, ovf_d;
  logic            c_into_msb;
`endif

  // Operands shift right each RUN cycle, so the active slice is always at [3:0].
  assign nib_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};

`ifdef OVERFLOW_FLAG_EN
  assign c_into_msb = a_q[3] ^ b_q[3] ^ nib_sum[3];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    co_d    = co_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        if (idx_q == IDX_LAST) begin
          co_d    = nib_sum[4];
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = c_into_msb ^ nib_sum[4];
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      co_q    <= co_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs decode the state register only; no path from in_valid/out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_co    = co_q;
`ifdef OVERFLOW_FLAG_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4: vector table plus backpressure and mid-op reset.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_co;
`ifdef OVERFLOW_FLAG_EN
  logic        out_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef OVERFLOW_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .out_co    (out_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake one operand set from IDLE and wait (bounded) for out_valid; returns cycles elapsed.
  task automatic start_add(input logic [15:0] a, input logic [15:0] b, input logic ci, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_ci = ~ci;
    chk("in_ready_run", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input logic [15:0] exp_sum);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("sum_hold", {16'd0, out_sum}, {16'd0, exp_sum});
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;
    vecs[0] = '{a:16'h1234, b:16'h4321, ci:1'b0, sum:16'h5555, co:1'b0, ovf:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, ci:1'b0, sum:16'h0000, co:1'b1, ovf:1'b0};
    vecs[2] = '{a:16'h000F, b:16'h0000, ci:1'b1, sum:16'h0010, co:1'b0, ovf:1'b0};
    vecs[3] = '{a:16'hFFFF, b:16'hFFFF, ci:1'b1, sum:16'hFFFF, co:1'b1, ovf:1'b0};
    vecs[4] = '{a:16'hABCD, b:16'h1111, ci:1'b0, sum:16'hBCDE, co:1'b0, ovf:1'b0};
    vecs[5] = '{a:16'h7FFF, b:16'h0001, ci:1'b0, sum:16'h8000, co:1'b0, ovf:1'b1};
    vecs[6] = '{a:16'h8000, b:16'h8000, ci:1'b0, sum:16'h0000, co:1'b1, ovf:1'b1};
    vecs[7] = '{a:16'hFFFF, b:16'h0000, ci:1'b1, sum:16'h0000, co:1'b1, ovf:1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_ci = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_co", {31'd0, out_co}, 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_add(vecs[i].a, vecs[i].b, vecs[i].ci, lat);
      chk($sformatf("latency[%0d]", i), lat, 32'd4);
      chk($sformatf("sum[%0d]", i), {16'd0, out_sum}, {16'd0, vecs[i].sum});
      chk($sformatf("co[%0d]", i), {31'd0, out_co}, {31'd0, vecs[i].co});
`ifdef OVERFLOW_FLAG_EN
      chk($sformatf("ovf[%0d]", i), {31'd0, out_ovf}, {31'd0, vecs[i].ovf});
`endif
      release_result(vecs[i].sum);
    end

    // Backpressure: DONE held while new operands are offered.
    start_add(16'h1234, 16'h4321, 1'b0, lat);
    chk("bp_latency", lat, 32'd4);
    in_a = 16'h0F0F; in_b = 16'h7777; in_ci = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_ready[%0d]", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_sum[%0d]", k), {16'd0, out_sum}, 32'h5555);
      chk($sformatf("bp_co[%0d]", k), {31'd0, out_co}, 32'd0);
    end
    in_valid = 1'b0;
    release_result(16'h5555);

    // Reset two cycles into RUN discards the partial result.
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h4321; in_ci = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_sum_partial", {16'd0, out_sum}, 32'h0055);
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_sum", {16'd0, out_sum}, 32'd0);
    chk("mr_out_co", {31'd0, out_co}, 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("mr_out_ovf", {31'd0, out_ovf}, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("mr_held_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_add(16'h0001, 16'h0001, 1'b0, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_sum", {16'd0, out_sum}, 32'h0002);
    chk("post_rst_co", {31'd0, out_co}, 32'd0);
    release_result(16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-word adder that computes a NIBBLES×4-bit sum one 4-bit slice per clock, passing the carry between slices in a register. It is the sequencing stage wrapped around the team's 4-bit full-adder datapath. It takes operand pairs from an upstream producer over a valid/ready handshake and presents the registered sum and carry-out to a downstream consumer over a second valid/ready handshake. This lets wide additions reuse one 4-bit adder slice instead of a full-width carry chain.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; legal range 1..8; W = 4*NIBBLES.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on in_a/in_b/in_ci is valid.
- in_ready  output  1  block accepts an operand set; high only in IDLE.
- in_a  input  W  operand A, unsigned (two's complement when overflow flag is compiled in).
- in_b  input  W  operand B.
- in_ci  input  1  carry-in into nibble 0.
- out_valid  output  1  out_sum/out_co/out_ovf hold a completed result.
- out_ready  input  1  consumer takes the result.
- out_sum  output  W  sum bits.
- out_co  output  1  carry-out of the top nibble.
- out_ovf  output  1  signed overflow; present only with OVERFLOW_FLAG_EN.

## Operation
- States: IDLE, RUN, DONE. Nibble counter idx has width clog2(NIBBLES), minimum 1 bit.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_a, in_b into operand shift registers and in_ci into the carry register;
  - set idx=0 and clear the sum register;
  - go to RUN.
- RUN: each cycle computes {c, s} = a[4·idx+3:4·idx] + b[4·idx+3:4·idx] + carry as a 5-bit add.
  - s is written into sum nibble idx; c becomes the new carry.
  - When idx==NIBBLES-1, the final c goes to out_co and the state moves to DONE. Otherwise idx increments.
- DONE: out_valid=1. out_sum and out_co stay stable. On out_valid&&out_ready, go to IDLE.
- While not in IDLE, in_valid is ignored. Operands are captured only at the handshake, so upstream may change in_a/in_b at any time after that.
- The result is exactly (in_a + in_b + in_ci) mod 2^W. out_co equals bit W of the full sum.
- NIBBLES=1: RUN lasts one cycle, and the block behaves as a registered 4-bit adder.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_co=0, out_ovf=0, carry=0, idx=0.
- Input handshake at edge E. Nibble k is written at edge E+1+k. out_valid rises after edge E+NIBBLES.
- Latency from input handshake to out_valid is NIBBLES cycles.
- Output handshake at edge F: out_valid=0 and in_ready=1 from F onward. The earliest next input handshake is at F+1.
- Maximum throughput is one addition per NIBBLES+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with all outputs frozen and in_ready=0.
- out_sum and out_co keep their last result after leaving DONE. They are qualified only by out_valid.
- Reset asserted in any state: aborts immediately and asynchronously to the reset values. A partial result is discarded and never presented.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.

## Configuration
- OVERFLOW_FLAG_EN defined:
  - port out_ovf exists;
  - in the last RUN cycle it is set to carry-into-MSB XOR carry-out-of-MSB of the top nibble;
  - it is registered alongside out_co and cleared by reset.
- OVERFLOW_FLAG_EN undefined: the out_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use NIBBLES=4.
- Basic add: in_a=0x1234, in_b=0x4321, in_ci=0 → out_sum=0x5555, out_co=0. out_valid rises exactly 4 cycles after the handshake.
- Full carry ripple: 0xFFFF + 0x0001, in_ci=0 → out_sum=0x0000, out_co=1.
- Carry-in use: 0x000F + 0x0000, in_ci=1 → out_sum=0x0010, out_co=0. Then 0xFFFF + 0xFFFF, in_ci=1 → out_sum=0xFFFF, out_co=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - out_valid stays 1 and in_ready stays 0; the result is unchanged and the new operands are ignored.
  - After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 two cycles into RUN → all outputs return to reset values at once. After release, 0x0001+0x0001 yields 0x0002.
- Overflow (OVERFLOW_FLAG_EN defined):
  - 0x7FFF+0x0001 → out_sum=0x8000, out_ovf=1, out_co=0.
  - 0x8000+0x8000 → out_sum=0x0000, out_ovf=1, out_co=1.
  - 0x1234+0x4321 → out_ovf=0.
